// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, instruction classes, opcodes, mux selects.
// Latency: none (declarations only); no backpressure.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_ADD, CL_SUB, CL_SLT, CL_JR, CL_J, CL_JAL,
        CL_BEQ, CL_BNE, CL_ADDI, CL_XORI, CL_LW, CL_SW
    } class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [1:0] DW_ALU = 2'd0;
    localparam logic [1:0] DW_PC4 = 2'd1;
    localparam logic [1:0] DW_MEM = 2'd2;

    localparam logic [1:0] J_DA    = 2'd0;
    localparam logic [1:0] J_TGT   = 2'd1;
    localparam logic [1:0] J_PCALU = 2'd2;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BEQ = 2'd1;
    localparam logic [1:0] PC_BNE = 2'd2;

    function automatic logic [2:0] class_alu_op(input class_e cls);
        case (cls)
            CL_SUB, CL_BEQ, CL_BNE: return ALU_SUB;
            CL_SLT:                 return ALU_SLT;
            CL_XORI:                return ALU_XOR;
            default:                return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in, enables/selects out.
// Latency: none (wiring only); memRdy is the only stall input.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zeroFlag;
    logic             memRdy;
    logic             memRdEn;
    logic             memWrEn;
    logic             irWrEn;
    logic             pcWrEn;
    logic             regWrEn;
    logic             immSel;
    logic             linkSel;
    logic [1:0]       DwSel;
    logic [1:0]       jSel;
    logic [1:0]       pcSel;
    logic [2:0]       aluOp;
    logic [2:0]       state;
    logic             trap;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zeroFlag, memRdy,
        output memRdEn, memWrEn, irWrEn, pcWrEn, regWrEn, immSel, linkSel,
               DwSel, jSel, pcSel, aluOp, state, trap, retired
    );

    modport slave (
        output opcode, funct, zeroFlag, memRdy,
        input  memRdEn, memWrEn, irWrEn, pcWrEn, regWrEn, immSel, linkSel,
               DwSel, jSel, pcSel, aluOp, state, trap, retired
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct -> instruction class plus illegal flag.
// Latency: 0 cycles; no backpressure.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output class_e     cls_o,
    output logic       illegal_o
);
    always_comb begin
        cls_o     = CL_ADD;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  cls_o = CL_ADD;
                    FN_SUB:  cls_o = CL_SUB;
                    FN_SLT:  cls_o = CL_SLT;
                    FN_JR:   cls_o = CL_JR;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_J:    cls_o = CL_J;
            OP_JAL:  cls_o = CL_JAL;
            OP_BEQ:  cls_o = CL_BEQ;
            OP_BNE:  cls_o = CL_BNE;
            OP_ADDI: cls_o = CL_ADDI;
            OP_XORI: cls_o = CL_XORI;
            OP_LW:   cls_o = CL_LW;
            OP_SW:   cls_o = CL_SW;
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving every datapath enable and select.
// Latency: 3-5 cycles per instruction plus memory wait; stalls in FETCH/MEM until memRdy, traps on timeout.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);
    localparam int               TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    class_e           cls_q, dec_cls;
    logic             dec_illegal;
    logic [TMO_W-1:0] tmo_q;
    logic [CNT_W-1:0] retired_q;
    logic             mem_wait, tmo_hit;
    logic             unused_zero;

    // Branch resolution on zeroFlag happens in the pcMux; the sequencer only picks the mode.
    assign unused_zero = bus.zeroFlag;

    multicycle_ctrl_decode u_decode (
        .opcode_i  (bus.opcode),
        .funct_i   (bus.funct),
        .cls_o     (dec_cls),
        .illegal_o (dec_illegal)
    );

    assign mem_wait = (state_q == ST_FETCH || state_q == ST_MEM) && !bus.memRdy;
    assign tmo_hit  = mem_wait && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (bus.memRdy) state_d = ST_DECODE;
                       else if (tmo_hit) state_d = ST_TRAP;
            ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                case (cls_q)
                    CL_LW, CL_SW:                              state_d = ST_MEM;
                    CL_ADD, CL_SUB, CL_SLT, CL_ADDI, CL_XORI:  state_d = ST_WB;
                    default:                                   state_d = ST_FETCH;
                endcase
            end
            ST_MEM:    if (bus.memRdy) state_d = (cls_q == CL_LW) ? ST_WB : ST_FETCH;
                       else if (tmo_hit) state_d = ST_TRAP;
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            cls_q     <= CL_ADD;
            tmo_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) cls_q <= dec_cls;
            tmo_q <= mem_wait ? tmo_q + 1'b1 : '0;
            if (bus.pcWrEn) retired_q <= retired_q + 1'b1;
        end
    end

    // Outputs are forced low while reset is held so an aborted store cannot linger.
    always_comb begin
        bus.memRdEn = 1'b0;
        bus.memWrEn = 1'b0;
        bus.irWrEn  = 1'b0;
        bus.pcWrEn  = 1'b0;
        bus.regWrEn = 1'b0;
        bus.immSel  = 1'b0;
        bus.linkSel = 1'b0;
        bus.DwSel   = DW_ALU;
        bus.jSel    = J_DA;
        bus.pcSel   = PC_INC;
        bus.aluOp   = ALU_ADD;
        bus.trap    = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    bus.memRdEn = !bus.memRdy;
                    bus.irWrEn  = bus.memRdy;
                end
                ST_EXEC: begin
                    bus.aluOp = class_alu_op(cls_q);
                    case (cls_q)
                        CL_ADDI, CL_XORI, CL_LW, CL_SW: bus.immSel = 1'b1;
                        CL_BEQ: begin bus.pcSel = PC_BEQ; bus.jSel = J_PCALU; bus.pcWrEn = 1'b1; end
                        CL_BNE: begin bus.pcSel = PC_BNE; bus.jSel = J_PCALU; bus.pcWrEn = 1'b1; end
                        CL_J:   begin bus.jSel = J_TGT; bus.pcWrEn = 1'b1; end
                        CL_JAL: begin
                            bus.jSel    = J_TGT;
                            bus.pcWrEn  = 1'b1;
                            bus.regWrEn = 1'b1;
                            bus.DwSel   = DW_PC4;
                            bus.linkSel = 1'b1;
                        end
                        CL_JR:  begin bus.jSel = J_DA; bus.pcWrEn = 1'b1; end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (cls_q == CL_LW) bus.memRdEn = 1'b1;
                    else                bus.memWrEn = 1'b1;
                    if (bus.memRdy && cls_q == CL_SW) begin
                        bus.pcWrEn = 1'b1;
                        bus.jSel   = J_PCALU;
                    end
                end
                ST_WB: begin
                    bus.regWrEn = 1'b1;
                    bus.DwSel   = (cls_q == CL_LW) ? DW_MEM : DW_ALU;
                    bus.pcWrEn  = 1'b1;
                    bus.jSel    = J_PCALU;
                end
                ST_TRAP:  bus.trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors queued by stimulus, checked by a negedge monitor.
module tb_multicycle_ctrl;
    localparam int CNT_W = 32;
    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;

    typedef struct packed {
        logic        memRdEn, memWrEn, irWrEn, pcWrEn, regWrEn, immSel, linkSel;
        logic [1:0]  DwSel, jSel, pcSel;
        logic [2:0]  aluOp, state;
        logic        trap;
        logic [31:0] retired;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    int    exp_ret     = 0;
    int    cyc         = 0;
    string tname       = "init";
    obs_t  exp_q[$];
    string tag_q[$];

    function automatic obs_t o(input logic [2:0] st);
        obs_t x;
        x         = '0;
        x.state   = st;
        x.retired = 32'(exp_ret);
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.memRdEn = bus.memRdEn;  s.memWrEn = bus.memWrEn;  s.irWrEn  = bus.irWrEn;
        s.pcWrEn  = bus.pcWrEn;   s.regWrEn = bus.regWrEn;  s.immSel  = bus.immSel;
        s.linkSel = bus.linkSel;  s.DwSel   = bus.DwSel;    s.jSel    = bus.jSel;
        s.pcSel   = bus.pcSel;    s.aluOp   = bus.aluOp;    s.state   = bus.state;
        s.trap    = bus.trap;     s.retired = bus.retired;
        return s;
    endfunction

    task automatic step(input logic rst, input logic rdy, input obs_t x);
        @(posedge clk);
        #1;
        reset      = rst;
        bus.memRdy = rdy;
        exp_q.push_back(x);
        tag_q.push_back($sformatf("%s.c%0d", tname, cyc));
        cyc++;
        if (x.pcWrEn) exp_ret++;
    endtask

    task automatic begin_test(input string n, input logic [5:0] op, input logic [5:0] fn);
        tname      = n;
        cyc        = 0;
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    task automatic do_reset();
        obs_t x;
        tname   = "reset";
        cyc     = 0;
        exp_ret = 0;
        x = o(F); step(1'b1, 1'b0, x);
        x = o(F); step(1'b1, 1'b0, x);
    endtask

    task automatic fetch(input int waits);
        obs_t x;
        for (int i = 0; i < waits; i++) begin
            x = o(F); x.memRdEn = 1'b1; step(1'b0, 1'b0, x);
        end
        x = o(F); x.irWrEn = 1'b1; step(1'b0, 1'b1, x);
        x = o(D); step(1'b0, 1'b1, x);
    endtask

    task automatic wb_alu();
        obs_t x;
        x = o(W); x.regWrEn = 1'b1; x.pcWrEn = 1'b1; x.jSel = 2'd2; step(1'b0, 1'b1, x);
    endtask

    task automatic run_add();
        obs_t x;
        begin_test("add", 6'h00, 6'h20);
        fetch(0);
        x = o(E); step(1'b0, 1'b1, x);
        wb_alu();
    endtask

    always @(negedge clk) begin : monitor
        obs_t  e, a;
        string t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = sample();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", t, a, e);
            end
        end
    end

    initial begin : stim
        obs_t x;
        reset        = 1'b1;
        bus.memRdy   = 1'b0;
        bus.opcode   = 6'h00;
        bus.funct    = 6'h00;
        bus.zeroFlag = 1'b0;
        do_reset();

        run_add();                                   // retired -> 1

        begin_test("lw", 6'h23, 6'h00);
        fetch(0);
        x = o(E); x.immSel = 1'b1; step(1'b0, 1'b1, x);
        for (int i = 0; i < 3; i++) begin
            x = o(M); x.memRdEn = 1'b1; step(1'b0, 1'b0, x);
        end
        x = o(M); x.memRdEn = 1'b1; step(1'b0, 1'b1, x);
        x = o(W); x.regWrEn = 1'b1; x.DwSel = 2'd2; x.pcWrEn = 1'b1; x.jSel = 2'd2;
        step(1'b0, 1'b1, x);                         // retired -> 2

        bus.zeroFlag = 1'b1;
        begin_test("beq", 6'h04, 6'h00);
        fetch(0);
        x = o(E); x.aluOp = 3'd1; x.pcSel = 2'd1; x.jSel = 2'd2; x.pcWrEn = 1'b1; step(1'b0, 1'b1, x);
        begin_test("bne", 6'h05, 6'h00);
        fetch(0);
        x = o(E); x.aluOp = 3'd1; x.pcSel = 2'd2; x.jSel = 2'd2; x.pcWrEn = 1'b1; step(1'b0, 1'b1, x);
        bus.zeroFlag = 1'b0;

        begin_test("jal", 6'h03, 6'h00);
        fetch(0);
        x = o(E); x.pcWrEn = 1'b1; x.regWrEn = 1'b1; x.linkSel = 1'b1; x.DwSel = 2'd1; x.jSel = 2'd1;
        step(1'b0, 1'b1, x);

        begin_test("sw", 6'h2b, 6'h00);
        fetch(0);
        x = o(E); x.immSel = 1'b1; step(1'b0, 1'b1, x);
        x = o(M); x.memWrEn = 1'b1; x.pcWrEn = 1'b1; x.jSel = 2'd2; step(1'b0, 1'b1, x);

        begin_test("xori", 6'h0e, 6'h00);
        fetch(0);
        x = o(E); x.aluOp = 3'd2; x.immSel = 1'b1; step(1'b0, 1'b1, x);
        wb_alu();

        begin_test("slt", 6'h00, 6'h2a);
        fetch(0);
        x = o(E); x.aluOp = 3'd3; step(1'b0, 1'b1, x);
        wb_alu();

        begin_test("jr", 6'h00, 6'h08);
        fetch(0);
        x = o(E); x.pcWrEn = 1'b1; step(1'b0, 1'b1, x);

        // memRdy on the 16th waiting cycle must beat the timeout
        begin_test("j_late_rdy", 6'h02, 6'h00);
        fetch(15);
        x = o(E); x.jSel = 2'd1; x.pcWrEn = 1'b1; step(1'b0, 1'b1, x);   // retired -> 10

        begin_test("illegal_op", 6'h3f, 6'h00);
        fetch(0);
        for (int i = 0; i < 3; i++) begin
            x = o(T); x.trap = 1'b1; step(1'b0, 1'b1, x);
        end
        do_reset();

        begin_test("illegal_fn", 6'h00, 6'h21);
        fetch(0);
        x = o(T); x.trap = 1'b1; step(1'b0, 1'b1, x);
        do_reset();

        begin_test("fetch_tmo", 6'h00, 6'h20);
        for (int i = 0; i < 16; i++) begin
            x = o(F); x.memRdEn = 1'b1; step(1'b0, 1'b0, x);
        end
        for (int i = 0; i < 3; i++) begin
            x = o(T); x.trap = 1'b1; step(1'b0, (i == 1), x);
        end
        do_reset();

        run_add();                                   // retired -> 1
        begin_test("sw_abort", 6'h2b, 6'h00);
        fetch(0);
        x = o(E); x.immSel = 1'b1; step(1'b0, 1'b0, x);
        for (int i = 0; i < 2; i++) begin
            x = o(M); x.memWrEn = 1'b1; step(1'b0, 1'b0, x);
        end
        do_reset();
        run_add();                                   // retired -> 1 again
        tname = "post_add";
        cyc   = 0;
        x = o(F); x.memRdEn = 1'b1; step(1'b0, 1'b0, x);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
